// File: rtl/dsp_simd_pkg.sv
// Constants and state type shared by the SIMD DSP adder-side packer and the
// output-side unpacker.
package dsp_simd_pkg;

  localparam int DSP_P_WIDTH = 48;
  localparam int LANE_STRIDE = 12;
  localparam int MAX_LANES   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } simd_unpack_state_t;

endpackage

// File: rtl/dsp_simd_unpack_if.sv
// Handshake bundle of the SIMD unpacker: packed P word + carries in, one
// tagged lane result per beat out.
interface dsp_simd_unpack_if
  import dsp_simd_pkg::*;
#(
  parameter int DATA_W = 12
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DSP_P_WIDTH-1:0] in_p;
  logic [MAX_LANES-1:0]   in_carry;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             out_lane;
  logic                   out_carry;
  logic                   out_last;

  modport master (
    output in_valid, in_p, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_carry, out_last
  );

  modport slave (
    input  in_valid, in_p, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_carry, out_last
  );

endinterface

// File: rtl/dsp_simd_unpack.sv
// Serialises one packed SIMD DSP P word into LANES scalar beats, each tagged
// with lane index, lane carry-out and a last-lane flag.
module dsp_simd_unpack
  import dsp_simd_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LANES  = 3
) (
  input  logic            clock,
  input  logic            reset,
  dsp_simd_unpack_if.slave bus
);

  if (DATA_W < 1 || DATA_W > LANE_STRIDE) begin : g_bad_width
    $error("dsp_simd_unpack: DATA_W=%0d outside 1..%0d", DATA_W, LANE_STRIDE);
  end
  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("dsp_simd_unpack: LANES=%0d outside 1..%0d", LANES, MAX_LANES);
  end

  localparam logic [1:0]           LAST_LANE  = 2'(LANES - 1);
  localparam logic [MAX_LANES-1:0] CARRY_MASK = MAX_LANES'((1 << LANES) - 1);

  simd_unpack_state_t     state_p1, state_nxt;
  logic [DSP_P_WIDTH-1:0] word_p1;
  logic [MAX_LANES-1:0]   carry_p1;
  logic [1:0]             cnt_p1, cnt_nxt;
  logic                   load;
  logic                   drain;
  logic                   is_last;
  logic [DATA_W-1:0]      lane_data;

  assign drain   = (state_p1 == DRAIN);
  assign is_last = (cnt_p1 == LAST_LANE);

  // A new word is taken when idle, or as the last lane of the held word leaves.
  assign bus.in_ready = !reset && (!drain || (bus.out_ready && is_last));

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    load      = 1'b0;
    case (state_p1)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          cnt_nxt   = 2'd0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (!is_last) begin
            cnt_nxt = cnt_p1 + 2'd1;
          end else if (bus.in_valid) begin
            load    = 1'b1;
            cnt_nxt = 2'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: hold register, lane counter and FSM state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p1 <= IDLE;
      cnt_p1   <= 2'd0;
      word_p1  <= '0;
      carry_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      if (load) begin
        word_p1  <= bus.in_p;
        carry_p1 <= bus.in_carry & CARRY_MASK;
      end
    end
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (cnt_p1 == 2'(i)) lane_data = word_p1[i*LANE_STRIDE +: DATA_W];
    end
  end

  // Outputs are driven purely from registered state, forced to zero when idle.
  assign bus.out_valid = drain;
  assign bus.out_data  = drain ? lane_data : '0;
  assign bus.out_lane  = drain ? cnt_p1 : 2'd0;
  assign bus.out_carry = drain & carry_p1[cnt_p1];
  assign bus.out_last  = drain & is_last;

endmodule
